// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite channel bundle between axi_lite_master_arbiter (master) and the
// shared register slave.
interface axi_lite_master_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port between two command requesters,
// one transaction in flight. Define ARB_STATS_EN to add per-requester/error counters.
module axi_lite_master_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
`ifdef ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  err_cnt,
`endif
  axi_lite_master_arbiter_if.master axi
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              last_grant;
  logic              grant;
  logic              start;
  logic              aw_done;
  logic              w_done;
  logic              aw_fire;
  logic              w_fire;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // A lone request wins outright; a tie goes to whoever was not served last.
  assign grant   = (req == 2'b10) ? 1'b1 :
                   (req == 2'b01) ? 1'b0 : ~last_grant;
  assign start   = (state == IDLE) && (req != 2'b00);
  assign aw_fire = (state == WR_ADDR) && !aw_done && axi.AWREADY;
  assign w_fire  = (state == WR_ADDR) && !w_done && axi.WREADY;

  assign axi.AWADDR = addr_q;
  assign axi.ARADDR = addr_q;
  assign axi.WDATA  = wdata_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ack         = 2'b00;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) state_nxt = we[grant] ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        axi.AWVALID = !aw_done;
        axi.WVALID  = !w_done;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        // BREADY is already high on entry so a one-cycle BVALID pulse is never missed.
        axi.BREADY = 1'b1;
        if (axi.BVALID) state_nxt = DONE;
      end
      RD_ADDR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        axi.RREADY = 1'b1;
        if (axi.RVALID) state_nxt = DONE;
      end
      DONE: begin
        ack[owner] = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata      <= '0;
      resp       <= 2'b00;
    end else begin
      if (start) begin
        owner      <= grant;
        last_grant <= grant;
        addr_q     <= grant ? addr1 : addr0;
        wdata_q    <= grant ? wdata1 : wdata0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if ((state == WR_RESP) && axi.BVALID) resp <= axi.BRESP;
      if ((state == RD_DATA) && axi.RVALID) begin
        rdata <= axi.RDATA;
        resp  <= axi.RRESP;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt0    <= '0;
      cnt1    <= '0;
      err_cnt <= '0;
    end else if (state == DONE) begin
      if (!owner && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (owner && (cnt1 != '1))  cnt1 <= cnt1 + CNT_W'(1);
      if ((resp != 2'b00) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Randomized scoreboard bench for axi_lite_master_arbiter: transaction-level model
// predicts owner order, rdata and resp; a bus-level slave with random stalls answers.
module tb_axi_lite_master_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
`ifdef ARB_STATS_EN
  localparam int CNT_W = 3;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [3:0]  addr0 = '0;
  logic [3:0]  addr1 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic [1:0]  resp;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1, err_cnt;
`endif

  axi_lite_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_master_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef ARB_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .req(req),
    .we(we),
    .addr0(addr0),
    .addr1(addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .ack(ack),
    .rdata(rdata),
    .resp(resp),
`ifdef ARB_STATS_EN
    .cnt0(cnt0),
    .cnt1(cnt1),
    .err_cnt(err_cnt),
`endif
    .axi(bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        owner;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  logic [31:0] m_mem [4];
  logic [31:0] m_rdata;
  logic        m_last;
  int          m_cnt0, m_cnt1, m_err;

  logic running = 1'b0;
  logic drop_req0 = 1'b0;
  logic busy0 = 1'b0;
  logic stall_r = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // The register slave rejects byte-misaligned addresses with SLVERR.
  function automatic logic [1:0] slaveResp(input logic [3:0] a);
    return (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
  endfunction

  function automatic cmd_t mkCmd(input logic w, input logic [3:0] a, input logic [31:0] d);
    cmd_t c;
    c.we = w;
    c.addr = a;
    c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t randCmd();
    logic [3:0] a;
    if ($urandom_range(0, 7) == 0) a = 4'($urandom_range(0, 15));
    else a = {2'($urandom_range(0, 3)), 2'b00};
    return mkCmd(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_rdata = '0;
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_err = 0;
  endtask

  // Both requesters present their queue heads back-to-back, so every arbitration
  // sees exactly the set of non-empty queues.
  task automatic issueModel();
    int   i0 = 0;
    int   i1 = 0;
    logic w;
    cmd_t c;
    exp_t e;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) w = ~m_last;
      else w = (i1 < q1.size());
      m_last = w;
      if (w) begin c = q1[i1]; i1++; end
      else   begin c = q0[i0]; i0++; end
      e.resp = slaveResp(c.addr);
      if (c.we) begin
        if (e.resp == 2'b00) m_mem[c.addr[3:2]] = c.wdata;
      end else begin
        m_rdata = (e.resp == 2'b00) ? m_mem[c.addr[3:2]] : 32'h0;
      end
      e.owner = w;
      e.we = c.we;
      e.addr = c.addr;
      e.wdata = c.wdata;
      e.rdata = m_rdata;
      if (w) m_cnt1++;
      else m_cnt0++;
      if (e.resp != 2'b00) m_err++;
      sb.push_back(e);
    end
  endtask

  task automatic doReset();
    running = 1'b0;
    ARESETn = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    repeat (2) @(negedge ACLK);
    modelReset();
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic applyStimulus(input string name);
    int n = 0;
    int budget;
    budget = 40 * (q0.size() + q1.size()) + 40;
    issueModel();
    running = 1'b1;
    while ((sb.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      doReset();
    end
    running = 1'b0;
    @(negedge ACLK);
`ifdef ARB_STATS_EN
    #1;
    checkOutput({name, "_cnt0"}, 32'(cnt0), (m_cnt0 > 7) ? 7 : m_cnt0);
    checkOutput({name, "_cnt1"}, 32'(cnt1), (m_cnt1 > 7) ? 7 : m_cnt1);
    checkOutput({name, "_err"}, 32'(err_cnt), (m_err > 7) ? 7 : m_err);
`endif
  endtask

  // Requester driver: keep presenting the queue head; retire it when its ack is seen.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        req = 2'b00;
        busy0 = 1'b0;
        continue;
      end
      if (ack[0] && q0.size() > 0) begin void'(q0.pop_front()); busy0 = 1'b0; end
      if (ack[1] && q1.size() > 0) void'(q1.pop_front());
      if (drop_req0 && (bus.ARVALID || bus.AWVALID)) busy0 = 1'b1;
      req[0] = running && (q0.size() > 0) && !busy0;
      req[1] = running && (q1.size() > 0);
      if (q0.size() > 0) begin we[0] = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
      if (q1.size() > 0) begin we[1] = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    end
  end

  // Four-register slave with random READY stalls and a one-cycle BVALID pulse.
  initial begin
    logic        have_aw, have_w, have_ar, r_hs;
    logic [3:0]  aw_a, ar_a;
    logic [31:0] w_d;
    logic [31:0] s_mem [4];
    int          b_dly, r_dly;
    have_aw = 0; have_w = 0; have_ar = 0; r_hs = 0;
    aw_a = '0; ar_a = '0; w_d = '0; b_dly = 0; r_dly = 0;
    for (int i = 0; i < 4; i++) s_mem[i] = '0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BRESP = 0; bus.RVALID = 0; bus.RRESP = 0; bus.RDATA = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        have_aw = 0; have_w = 0; have_ar = 0; r_hs = 0;
        for (int i = 0; i < 4; i++) s_mem[i] = '0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
        bus.BVALID = 0; bus.RVALID = 0;
        continue;
      end
      if (bus.BVALID) bus.BVALID = 0;
      if (r_hs) begin bus.RVALID = 0; have_ar = 0; end
      if (have_aw && have_w) begin
        if (b_dly > 0) b_dly--;
        else begin
          bus.BRESP = slaveResp(aw_a);
          if (bus.BRESP == 2'b00) s_mem[aw_a[3:2]] = w_d;
          bus.BVALID = 1;
          have_aw = 0;
          have_w = 0;
        end
      end
      if (have_ar && !bus.RVALID && !stall_r) begin
        if (r_dly > 0) r_dly--;
        else begin
          bus.RRESP = slaveResp(ar_a);
          bus.RDATA = (bus.RRESP == 2'b00) ? s_mem[ar_a[3:2]] : 32'h0;
          bus.RVALID = 1;
        end
      end
      bus.AWREADY = bus.AWVALID && !have_aw && ($urandom_range(0, 2) == 0);
      bus.WREADY  = bus.WVALID && !have_w && ($urandom_range(0, 2) == 0);
      bus.ARREADY = bus.ARVALID && !have_ar && ($urandom_range(0, 2) == 0);
      if (bus.AWVALID && bus.AWREADY) begin have_aw = 1; aw_a = bus.AWADDR; b_dly = $urandom_range(0, 2); end
      if (bus.WVALID && bus.WREADY) begin have_w = 1; w_d = bus.WDATA; b_dly = $urandom_range(0, 2); end
      if (bus.ARVALID && bus.ARREADY) begin have_ar = 1; ar_a = bus.ARADDR; r_dly = $urandom_range(0, 3); end
      r_hs = bus.RVALID && bus.RREADY;
    end
  end

  // Monitor: bus-phase checks against the scoreboard head, and ack/rdata/resp on every ack.
  initial begin
    logic exp_ack, aw_prev, w_prev, aw_wait, w_wait;
    exp_t e;
    exp_ack = 0; aw_prev = 0; w_prev = 0; aw_wait = 0; w_wait = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETn) begin
        exp_ack = 0; aw_prev = 0; w_prev = 0; aw_wait = 0; w_wait = 0;
        continue;
      end
      if (exp_ack) checkOutput("ack_latency", 32'(ack != 2'b00), 32'd1);
      if (aw_prev) checkOutput("awvalid_drop", 32'(bus.AWVALID), 32'd0);
      if (w_prev)  checkOutput("wvalid_drop", 32'(bus.WVALID), 32'd0);
      if (aw_wait) checkOutput("awvalid_hold", 32'(bus.AWVALID), 32'd1);
      if (w_wait)  checkOutput("wvalid_hold", 32'(bus.WVALID), 32'd1);
      if (sb.size() > 0) begin
        if (bus.AWVALID && bus.AWREADY) begin
          checkOutput("awaddr", 32'(bus.AWADDR), 32'(sb[0].addr));
          checkOutput("aw_is_write", 32'(sb[0].we), 32'd1);
        end
        if (bus.WVALID && bus.WREADY) checkOutput("wdata", bus.WDATA, sb[0].wdata);
        if (bus.ARVALID && bus.ARREADY) begin
          checkOutput("araddr", 32'(bus.ARADDR), 32'(sb[0].addr));
          checkOutput("ar_is_read", 32'(sb[0].we), 32'd0);
        end
      end
      aw_prev = bus.AWVALID && bus.AWREADY;
      w_prev  = bus.WVALID && bus.WREADY;
      aw_wait = bus.AWVALID && !bus.AWREADY;
      w_wait  = bus.WVALID && !bus.WREADY;
      exp_ack = (bus.BVALID && bus.BREADY) || (bus.RVALID && bus.RREADY);
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_owner", 32'(ack), e.owner ? 32'd2 : 32'd1);
          checkOutput("resp", 32'(resp), 32'(e.resp));
          checkOutput("rdata", rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int n;
    modelReset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_resp", 32'(resp), 32'd0);
    checkOutput("rst_valids", 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
    checkOutput("rst_readies", 32'({bus.BREADY, bus.RREADY}), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    $display("[TB] simultaneous requests, 8 pairs");
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mkCmd(1'b0, {2'(i), 2'b00}, 32'h0));
      q1.push_back(mkCmd(1'b0, {2'(i + 1), 2'b00}, 32'h0));
    end
    applyStimulus("arb_pairs");

    $display("[TB] write then read back");
    q0.push_back(mkCmd(1'b1, 4'h4, 32'hDEADBEEF));
    q0.push_back(mkCmd(1'b0, 4'h4, 32'h0));
    applyStimulus("wr_rd");

    $display("[TB] four registers via alternating requesters");
    q0.push_back(mkCmd(1'b1, 4'h0, 32'd1));
    q1.push_back(mkCmd(1'b1, 4'h4, 32'd2));
    q0.push_back(mkCmd(1'b1, 4'h8, 32'd3));
    q1.push_back(mkCmd(1'b1, 4'hC, 32'd4));
    applyStimulus("four_wr");
    q0.push_back(mkCmd(1'b0, 4'h0, 32'h0));
    q1.push_back(mkCmd(1'b0, 4'h4, 32'h0));
    q0.push_back(mkCmd(1'b0, 4'h8, 32'h0));
    q1.push_back(mkCmd(1'b0, 4'hC, 32'h0));
    applyStimulus("four_rd");

    $display("[TB] random traffic");
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) q0.push_back(randCmd());
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) q1.push_back(randCmd());
      applyStimulus("random");
    end

    $display("[TB] request withdrawn mid-transaction");
    drop_req0 = 1'b1;
    q0.push_back(mkCmd(1'b0, 4'h4, 32'h0));
    applyStimulus("drop_req");
    drop_req0 = 1'b0;

    $display("[TB] reset during read data phase");
    stall_r = 1'b1;
    q0.push_back(mkCmd(1'b0, 4'h8, 32'h0));
    issueModel();
    running = 1'b1;
    n = 0;
    while (!bus.RREADY && n < 60) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("[TB] FAIL rd_data_wait: got RREADY=%b expected 1", bus.RREADY);
    end
    ARESETn = 1'b0;
    @(negedge ACLK);
    #1;
    checkOutput("rst_mid_arvalid", 32'(bus.ARVALID), 32'd0);
    checkOutput("rst_mid_rready", 32'(bus.RREADY), 32'd0);
    checkOutput("rst_mid_ack", 32'(ack), 32'd0);
    checkOutput("rst_mid_rdata", rdata, 32'd0);
    running = 1'b0;
    stall_r = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    modelReset();
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    q0.push_back(mkCmd(1'b0, 4'h0, 32'h0));
    applyStimulus("post_rst_rd");
    q0.push_back(mkCmd(1'b1, 4'h0, 32'hA5A5_0F0F));
    q1.push_back(mkCmd(1'b0, 4'h0, 32'h0));
    applyStimulus("post_rst_wr_rd");

`ifdef ARB_STATS_EN
    $display("[TB] counter saturation");
    for (int k = 0; k < 9; k++) q0.push_back(mkCmd(1'b1, 4'h4, 32'(k)));
    applyStimulus("sat");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
